// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Message-granular round-robin arbiter sharing one UART TX core
//               between several byte producers, with lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_write,
    output logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          lock_tmo
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ISSUE  = 3'd1;
    localparam logic [2:0] c_BLANK  = 3'd2;
    localparam logic [2:0] c_WAIT   = 3'd3;
    localparam logic [2:0] c_LOCKED = 3'd4;

    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_PTR_W:0]   c_NUM      = (c_PTR_W + 1)'(NUM_REQ);

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [c_PTR_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_tx_write;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic                   r_lock_tmo;
    logic [c_CNT_W-1:0]     r_tmo_cnt;
    logic                   r_last_q;

    logic [c_PTR_W:0]       w_scan;
    logic [c_PTR_W:0]       w_owner_inc;
    logic [c_PTR_W-1:0]     w_ptr_next;
    logic [c_PTR_W-1:0]     w_win_idx;
    logic                   w_win_found;
    logic [c_PTR_W-1:0]     w_sel_idx;
    logic [DATA_BITS-1:0]   w_sel_data;
    logic                   w_sel_last;
    logic [NUM_REQ-1:0]     w_ready;
    logic [NUM_REQ-1:0]     w_acc_vec;
    logic                   w_accept;
    logic                   w_tmo_hit;

    // Round-robin scan starting at r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(k);
            if (w_scan >= c_NUM) w_scan = w_scan - c_NUM;
            if (!w_win_found && req_valid[w_scan[c_PTR_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_owner_inc = {1'b0, r_owner} + 1'b1;
        if (w_owner_inc == c_NUM) w_owner_inc = '0;
        w_ptr_next = w_owner_inc[c_PTR_W-1:0];
    end

    assign w_sel_idx  = (r_state == c_LOCKED) ? r_owner : w_win_idx;
    assign w_sel_data = req_data[w_sel_idx*DATA_BITS +: DATA_BITS];
    assign w_sel_last = req_last[w_sel_idx];

    // Output decode: only the RR winner (IDLE) or the lock owner sees ready.
    always_comb begin
        w_ready = '0;
        case (r_state)
            c_IDLE:   if (w_win_found) w_ready[w_win_idx] = tx_ready;
            c_LOCKED: w_ready[r_owner] = tx_ready;
            default:  w_ready = '0;
        endcase
        if (rst) w_ready = '0;
    end

    assign w_acc_vec = req_valid & w_ready;
    assign w_accept  = |w_acc_vec;
    assign w_tmo_hit = (r_state == c_LOCKED) && !w_accept && (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE:   w_next_state = w_accept ? c_ISSUE : c_IDLE;
            c_ISSUE:  w_next_state = c_BLANK;
            c_BLANK:  w_next_state = c_WAIT;
            c_WAIT:   w_next_state = !tx_ready ? c_WAIT : (r_last_q ? c_IDLE : c_LOCKED);
            c_LOCKED: w_next_state = w_accept ? c_ISSUE : (w_tmo_hit ? c_IDLE : c_LOCKED);
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_tx_write <= 1'b0;
            r_tx_data  <= '0;
            r_lock_tmo <= 1'b0;
            r_tmo_cnt  <= '0;
            r_last_q   <= 1'b0;
        end else begin
            r_tx_write <= w_accept;
            r_lock_tmo <= w_tmo_hit;
            if (w_accept) begin
                r_tx_data <= w_sel_data;
                r_last_q  <= w_sel_last;
                r_owner   <= w_sel_idx;
                r_grant   <= w_acc_vec;
            end
            if (r_state == c_WAIT && tx_ready) begin
                if (r_last_q) begin
                    r_grant  <= '0;
                    r_rr_ptr <= w_ptr_next;
                end else begin
                    r_tmo_cnt <= '0;
                end
            end
            if (r_state == c_LOCKED && !w_accept) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_tmo_hit) begin
                r_grant  <= '0;
                r_rr_ptr <= w_ptr_next;
            end
            if (r_state > c_LOCKED) r_grant <= '0;
        end
    end

    assign req_ready = w_ready;
    assign tx_write  = r_tx_write;
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign busy      = (r_state != c_IDLE);
    assign lock_tmo  = r_lock_tmo;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed scenarios plus randomized message traffic checked
//               against a message-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic            tx_write, tx_ready, busy, lock_tmo;
    logic [DW-1:0]   tx_data;

    int           n_vec = 0;
    int           n_err = 0;
    bit           autodrop;
    logic [N-1:0] last_acc, ready_seen;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_write(tx_write),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
        .lock_tmo(lock_tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got no_finish exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        #1;
        last_acc   = req_valid & req_ready;
        ready_seen = ready_seen | req_ready;
        @(posedge clk);
        #1;
        if (autodrop) req_valid = req_valid & ~last_acc;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l);
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = d;
        req_last[i]          = l;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        tx_ready = 1'b1; autodrop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_write(output logic [7:0] d, output logic [N-1:0] g, output bit got);
        got = 1'b0; d = '0; g = '0;
        for (int c = 0; c < 200 && !got; c++) begin
            cyc();
            if (tx_write) begin got = 1'b1; d = tx_data; g = grant; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = '0; req_last = '1; tx_ready = 1'b1; autodrop = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (grant !== 4'b0)    begin n_err++; $display("FAIL reset_grant got %b exp 0000", grant); end
        n_vec++; if (tx_write !== 1'b0) begin n_err++; $display("FAIL reset_tx_write got %b exp 0", tx_write); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (lock_tmo !== 1'b0) begin n_err++; $display("FAIL reset_lock_tmo got %b exp 0", lock_tmo); end
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        do_reset();
    endtask

    task automatic test_single();
        set_req(0, 8'h41, 1'b1);
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        cyc();
        n_vec++; if (tx_write !== 1'b1 || tx_data !== 8'h41 || grant !== 4'b0001)
            begin n_err++; $display("FAIL single_issue got w=%b d=%h g=%b exp w=1 d=41 g=0001", tx_write, tx_data, grant); end
        tx_ready = 1'b0;
        repeat (5) cyc();
        n_vec++; if (grant !== 4'b0001 || busy !== 1'b1 || tx_write !== 1'b0)
            begin n_err++; $display("FAIL single_wait got g=%b b=%b w=%b exp g=0001 b=1 w=0", grant, busy, tx_write); end
        tx_ready = 1'b1;
        cyc();
        n_vec++; if (grant !== 4'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL single_idle got g=%b b=%b exp g=0000 b=0", grant, busy); end
        set_req(0, 8'h01, 1'b1); set_req(1, 8'h02, 1'b1);
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_rrptr got %b exp 0010", req_ready); end
        req_valid = '0;
        do_reset();
    endtask

    task automatic test_contention();
        logic [7:0] d; logic [N-1:0] g, eg; bit got;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i), 1'b1);
            for (int k = 0; k < N; k++) begin
                wait_write(d, g, got);
                eg = 4'b0001 << k;
                n_vec++; if (!got || d !== 8'h10 + 8'(k) || g !== eg)
                    begin n_err++; $display("FAIL contention r%0d k%0d got %0b/%h/%b exp 1/%h/%b", r, k, got, d, g, 8'h10 + 8'(k), eg); end
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] d; logic [N-1:0] g, eg; bit got;
        logic [7:0] msg [4];
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0A; msg[3] = 8'h55;
        ready_seen = '0;
        set_req(1, msg[0], 1'b0); set_req(2, 8'h55, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_write(d, g, got);
            eg = (k < 3) ? 4'b0010 : 4'b0100;
            n_vec++; if (!got || d !== msg[k] || g !== eg)
                begin n_err++; $display("FAIL lock_order k%0d got %0b/%h/%b exp 1/%h/%b", k, got, d, g, msg[k], eg); end
            if (k == 0) set_req(1, msg[1], 1'b0);
            if (k == 1) set_req(1, msg[2], 1'b1);
            if (k == 2) begin
                n_vec++; if (ready_seen[2] !== 1'b0) begin n_err++; $display("FAIL lock_blocks_req2 got %b exp 0", ready_seen[2]); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d; logic [N-1:0] g; bit got; int bad;
        set_req(3, 8'h33, 1'b0); set_req(0, 8'hA5, 1'b1);
        wait_write(d, g, got);
        n_vec++; if (!got || d !== 8'h33 || g !== 4'b1000)
            begin n_err++; $display("FAIL tmo_first got %0b/%h/%b exp 1/33/1000", got, d, g); end
        ready_seen = '0; bad = 0;
        for (int c = 1; c <= LT + 3; c++) begin
            cyc();
            if (c < LT + 3 && lock_tmo) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL tmo_early got %0d exp 0", bad); end
        n_vec++; if (lock_tmo !== 1'b1 || grant !== 4'b0)
            begin n_err++; $display("FAIL tmo_pulse got t=%b g=%b exp t=1 g=0000", lock_tmo, grant); end
        n_vec++; if (req_ready !== 4'b0001 || ready_seen[0] !== 1'b0)
            begin n_err++; $display("FAIL tmo_handover got %b seen=%b exp 0001 seen=0", req_ready, ready_seen[0]); end
        wait_write(d, g, got);
        n_vec++; if (!got || d !== 8'hA5 || g !== 4'b0001 || lock_tmo !== 1'b0)
            begin n_err++; $display("FAIL tmo_next got %0b/%h/%b/%b exp 1/a5/0001/0", got, d, g, lock_tmo); end
    endtask

    task automatic test_tmo_boundary();
        logic [7:0] d; logic [N-1:0] g; bit got;
        set_req(1, 8'h61, 1'b0);
        wait_write(d, g, got);
        n_vec++; if (!got || d !== 8'h61 || g !== 4'b0010)
            begin n_err++; $display("FAIL bnd_first got %0b/%h/%b exp 1/61/0010", got, d, g); end
        repeat (LT + 2) cyc();
        set_req(1, 8'h62, 1'b1);
        cyc();
        n_vec++; if (last_acc !== 4'b0010 || lock_tmo !== 1'b0 || tx_write !== 1'b1 || tx_data !== 8'h62)
            begin n_err++; $display("FAIL bnd_accept got a=%b t=%b w=%b d=%h exp a=0010 t=0 w=1 d=62", last_acc, lock_tmo, tx_write, tx_data); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d; logic [N-1:0] g; bit got; int writes, bad;
        set_req(2, 8'h77, 1'b1);
        wait_write(d, g, got);
        n_vec++; if (!got || d !== 8'h77 || g !== 4'b0100)
            begin n_err++; $display("FAIL bp_first got %0b/%h/%b exp 1/77/0100", got, d, g); end
        tx_ready = 1'b0; set_req(0, 8'h78, 1'b1); ready_seen = '0; writes = 0; bad = 0;
        repeat (500) begin
            cyc();
            if (tx_write) writes++;
            if (!busy) bad++;
        end
        n_vec++; if (writes != 0 || ready_seen !== 4'b0 || bad != 0 || grant !== 4'b0100)
            begin n_err++; $display("FAIL bp_stall got w=%0d r=%b nb=%0d g=%b exp 0/0000/0/0100", writes, ready_seen, bad, grant); end
        tx_ready = 1'b1;
        wait_write(d, g, got);
        n_vec++; if (!got || d !== 8'h78 || g !== 4'b0001)
            begin n_err++; $display("FAIL bp_resume got %0b/%h/%b exp 1/78/0001", got, d, g); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic [N-1:0] g; bit got;
        set_req(1, 8'h99, 1'b1);
        wait_write(d, g, got);
        cyc();
        rst = 1'b1;
        #1;
        n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL rstmid_async got %b exp 0000", grant); end
        cyc();
        n_vec++; if (grant !== 4'b0 || tx_write !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL rstmid_state got g=%b w=%b b=%b exp 0000/0/0", grant, tx_write, busy); end
        rst = 1'b0;
        set_req(3, 8'h03, 1'b1); set_req(0, 8'h00, 1'b1);
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_winner got %b exp 0001", req_ready); end
        do_reset();
    endtask

    task automatic test_random(input int round);
        logic [8:0] rq [N][$];
        logic [8:0] cq [N][$];
        logic [9:0] exp_q [$];
        logic [9:0] e;
        logic [8:0] b;
        logic [N-1:0] eg;
        int ptr, found, core_busy, lock_bad, nmsg, len;
        do_reset();
        autodrop = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            nmsg = $urandom_range(0, 3);
            for (int m = 0; m < nmsg; m++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) rq[i].push_back({(k == len - 1), 8'($urandom)});
            end
            cq[i] = rq[i];
        end
        // Reference: whole messages leave in round-robin order of requesters.
        ptr = 0;
        for (int guard = 0; guard < 64; guard++) begin
            found = -1;
            for (int k = 0; k < N; k++)
                if (found < 0 && cq[(ptr + k) % N].size() > 0) found = (ptr + k) % N;
            if (found < 0) break;
            do begin
                b = cq[found].pop_front();
                exp_q.push_back({2'(found), b[7:0]});
            end while (!b[8]);
            ptr = (found + 1) % N;
        end
        core_busy = 0; lock_bad = 0;
        for (int c = 0; c < 4000 && (exp_q.size() > 0 || busy); c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) begin
                    req_data[i*DW +: DW] = rq[i][0][7:0];
                    req_last[i]          = rq[i][0][8];
                end
            end
            cyc();
            for (int i = 0; i < N; i++)
                if (last_acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (lock_tmo) lock_bad++;
            if (tx_write) begin
                e  = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                eg = 4'b0001 << e[9:8];
                n_vec++; if (tx_data !== e[7:0] || grant !== eg)
                    begin n_err++; $display("FAIL rand%0d_byte got %h/%b exp %h/%b", round, tx_data, grant, e[7:0], eg); end
                core_busy = $urandom_range(0, 6);
                tx_ready  = (core_busy == 0);
            end else if (core_busy > 0) begin
                core_busy--;
                tx_ready = (core_busy == 0);
            end
        end
        n_vec++; if (exp_q.size() != 0 || lock_bad != 0)
            begin n_err++; $display("FAIL rand%0d_end got left=%0d tmo=%0d exp 0/0", round, exp_q.size(), lock_bad); end
        req_valid = '0;
        tx_ready  = 1'b1;
    endtask

    initial begin
        last_acc = '0; ready_seen = '0;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_tmo_boundary();
        test_backpressure();
        test_reset_mid();
        for (int r = 0; r < 4; r++) test_random(r);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
